dma_2d_desc_sequencer: RTL

Descriptor-queue controller for the 2D DMA engine. It buffers up to DEPTH 2D transfer descriptors from the register/CPU side. For each descriptor it drives the read-master and write-master configuration and start pulses, waits until both masters report completion, then raises a completion interrupt. It sits between the AXI-Lite register block and the Read_Master/FIFO/Write_Master datapath, and is the only block that starts those masters.

---
 rtl/dma_2d_desc_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dma_2d_desc_sequencer.sv
// Descriptor queue and sequencer for the 2D DMA engine: pops one 2D descriptor at a time,
// starts the read/write masters together and raises an interrupt once both have finished.
module dma_2d_desc_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_desc_valid,
  output logic                   o_desc_ready,
  input  logic [31:0]            i_desc_src,
  input  logic [31:0]            i_desc_dst,
  input  logic [31:0]            i_desc_width,
  input  logic [31:0]            i_desc_height,
  input  logic [31:0]            i_desc_src_stride,
  input  logic [31:0]            i_desc_dst_stride,
  input  logic                   i_flush,
  output logic [31:0]            o_src_addr,
  output logic [31:0]            o_dst_addr,
  output logic [31:0]            o_img_width,
  output logic [31:0]            o_img_height,
  output logic [31:0]            o_src_stride,
  output logic [31:0]            o_dst_stride,
  output logic                   o_rd_start,
  output logic                   o_wr_start,
  input  logic                   i_read_done,
  input  logic                   i_write_done,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_irq,
  output logic                   o_irq_err,
  output logic [CNT_W-1:0]       o_done_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = 6 * 32;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_RETIRE} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          ready_en;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          rd_done_q;
  logic          wr_done_q;
  logic          rd_rise;
  logic          wr_rise;
  logic          rd_seen;
  logic          wr_seen;
  logic          err;
  logic          desc_bad;

  assign full         = (o_level == FULL_LVL);
  assign empty        = (o_level == '0);
  assign o_desc_ready = ready_en && !full && !i_flush;
  assign push         = i_desc_valid && o_desc_ready;
  assign pop          = (state == S_IDLE) && !empty;
  assign head         = mem[rd_ptr];
  assign o_busy       = (state != S_IDLE) || !empty;

  // Only rising edges count, so done levels left high by the previous transfer are ignored.
  assign rd_rise  = i_read_done && !rd_done_q;
  assign wr_rise  = i_write_done && !wr_done_q;
  assign desc_bad = (o_img_width == '0) || (o_img_height == '0) || (o_img_width[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_desc_src, i_desc_dst, i_desc_width, i_desc_height,
                      i_desc_src_stride, i_desc_dst_stride};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_level  <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (i_flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        o_level <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      o_level <= o_level + 1'b1;
        else if (!push && pop) o_level <= o_level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      o_src_addr   <= '0;
      o_dst_addr   <= '0;
      o_img_width  <= '0;
      o_img_height <= '0;
      o_src_stride <= '0;
      o_dst_stride <= '0;
      o_rd_start   <= 1'b0;
      o_wr_start   <= 1'b0;
      o_irq        <= 1'b0;
      o_irq_err    <= 1'b0;
      o_done_count <= '0;
      rd_done_q    <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_seen      <= 1'b0;
      wr_seen      <= 1'b0;
      err          <= 1'b0;
    end else begin
      o_rd_start <= 1'b0;
      o_wr_start <= 1'b0;
      o_irq      <= 1'b0;
      o_irq_err  <= 1'b0;
      rd_done_q  <= i_read_done;
      wr_done_q  <= i_write_done;
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            state <= S_LOAD;
            {o_src_addr, o_dst_addr, o_img_width, o_img_height,
             o_src_stride, o_dst_stride} <= head;
          end
        end
        S_LOAD: begin
          err <= desc_bad;
          if (desc_bad) begin
            state     <= S_RETIRE;
            o_irq     <= 1'b1;
            o_irq_err <= 1'b1;
          end else begin
            state      <= S_START;
            o_rd_start <= 1'b1;
            o_wr_start <= 1'b1;
          end
        end
        S_START: begin
          rd_seen <= 1'b0;
          wr_seen <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          rd_seen <= rd_seen || rd_rise;
          wr_seen <= wr_seen || wr_rise;
          if ((rd_seen || rd_rise) && (wr_seen || wr_rise)) begin
            state     <= S_RETIRE;
            o_irq     <= 1'b1;
            o_irq_err <= err;
            if (!err) o_done_count <= o_done_count + 1'b1;
          end
        end
        S_RETIRE: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
